// File: rtl/stack_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : stack_control_unit
//  Description : Sequencer for a stack machine. Fetches 16-bit instructions
//                ([15:11] opcode, [10:0] immediate), decodes them and issues
//                one-cycle stack/temp strobes to the datapath. Every output is
//                taken straight from a flop.
//  Ports       : clk, reset (async, active-high)
//                start                 - pulse, (re)starts fetching at pc=0
//                instr_req/pc          - fetch request and address
//                instr/instr_valid     - fetched word, sampled while instr_req=1
//                pilha_en/wren         - stack strobe, 1=push 0=pop
//                controle_pilha        - push source: 0=din_UC, 1=ALU result
//                load_temp1/2, temp_en - temp register capture of tos
//                opcode, din_UC        - ALU opcode and sign-extended immediate
//                busy/halted/error     - status flags
//  Option      : `define STACK_GUARD_EN adds a stack depth counter that blocks
//                overflowing/underflowing instructions and flags error.
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_control_unit #(
    parameter int PC_W  = 8,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            instr_req,
    output logic [PC_W-1:0] pc,
    input  logic [15:0]     instr,
    input  logic            instr_valid,
    output logic            pilha_en,
    output logic            wren,
    output logic            controle_pilha,
    output logic            load_temp1,
    output logic            load_temp2,
    output logic            temp_en,
    output logic [4:0]      opcode,
    output logic [15:0]     din_UC,
    output logic            busy,
    output logic            halted,
    output logic            error
);

    localparam logic [4:0] c_OP_NOP  = 5'b00000;
    localparam logic [4:0] c_OP_PUSH = 5'b00001;
    localparam logic [4:0] c_OP_POP  = 5'b00010;
    localparam logic [4:0] c_OP_HALT = 5'b11111;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_PUSH   = 4'd3,
        S_POP    = 4'd4,
        S_POP_A  = 4'd5,
        S_POP_B  = 4'd6,
        S_EXEC   = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    // Binary ALU operations consume two operands, so the stack must be at
    // least two deep for the depth guard to make sense.
    generate
        if (DEPTH < 2) begin : g_depth_check
            $error("stack_control_unit: DEPTH must be at least 2");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic              error_q, error_d;
    logic              instr_req_q, instr_req_d;
    logic              pilha_en_q, pilha_en_d;
    logic              wren_q, wren_d;
    logic              controle_pilha_q, controle_pilha_d;
    logic              load_temp1_q, load_temp1_d;
    logic              load_temp2_q, load_temp2_d;
    logic              temp_en_q, temp_en_d;
    logic [4:0]        opcode_q, opcode_d;
    logic [15:0]       din_uc_q, din_uc_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;

    logic              push_block, pop_block, alu_block;
    logic [4:0]        dec_op;
    logic              dec_alu;

`ifdef STACK_GUARD_EN
    localparam int DEPTH_W = $clog2(DEPTH + 1);
    logic [DEPTH_W-1:0] depth_q, depth_d;

    assign push_block = (depth_q == DEPTH_W'(DEPTH));
    assign pop_block  = (depth_q == '0);
    assign alu_block  = (depth_q < DEPTH_W'(2));

    // Depth moves when a stack strobe is about to be issued, i.e. on entry
    // to a strobing state, so DECODE always sees the fully settled depth.
    always_comb begin
        depth_d = depth_q;
        case (state_d)
            S_PUSH, S_EXEC:         depth_d = depth_q + DEPTH_W'(1);
            S_POP, S_POP_A, S_POP_B: depth_d = depth_q - DEPTH_W'(1);
            default:                depth_d = depth_q;
        endcase
    end
`else
    assign push_block = 1'b0;
    assign pop_block  = 1'b0;
    assign alu_block  = 1'b0;
`endif

    assign dec_op  = instr_q[15:11];
    assign dec_alu = (dec_op[4] == 1'b0) && (dec_op[3:2] != 2'b00);  // 00100..01111

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        error_d = error_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    error_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (instr_valid) begin
                    instr_d = instr;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_FETCH;
                if (dec_op == c_OP_NOP) begin
                    state_d = S_FETCH;
                end else if (dec_op == c_OP_PUSH) begin
                    if (push_block) error_d = 1'b1;
                    else            state_d = S_PUSH;
                end else if (dec_op == c_OP_POP) begin
                    if (pop_block)  error_d = 1'b1;
                    else            state_d = S_POP;
                end else if (dec_alu) begin
                    if (alu_block)  error_d = 1'b1;
                    else            state_d = S_POP_A;
                end else if (dec_op == c_OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    error_d = 1'b1;   // illegal opcode behaves as NOP
                end
            end
            S_PUSH, S_POP, S_EXEC: state_d = S_FETCH;
            S_POP_A:               state_d = S_POP_B;
            S_POP_B:               state_d = S_EXEC;
            default:               state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so that they can be
        // registered and still line up with the state they describe.
        instr_req_d      = (state_d == S_FETCH);
        pilha_en_d       = (state_d == S_PUSH) || (state_d == S_POP) ||
                           (state_d == S_POP_A) || (state_d == S_POP_B) ||
                           (state_d == S_EXEC);
        wren_d           = (state_d == S_PUSH) || (state_d == S_EXEC);
        controle_pilha_d = (state_d == S_EXEC);
        temp_en_d        = (state_d == S_POP_A) || (state_d == S_POP_B);
        load_temp1_d     = (state_d == S_POP_A);
        load_temp2_d     = (state_d == S_POP_B);
        busy_d           = (state_d != S_IDLE) && (state_d != S_HALT);
        halted_d         = (state_d == S_HALT);
        opcode_d         = (pilha_en_d || state_d == S_DECODE) ? instr_d[15:11] : 5'd0;
        din_uc_d         = (state_d == S_PUSH) ? {{5{instr_d[10]}}, instr_d[10:0]} : 16'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            pc_q             <= '0;
            instr_q          <= '0;
            error_q          <= 1'b0;
            instr_req_q      <= 1'b0;
            pilha_en_q       <= 1'b0;
            wren_q           <= 1'b0;
            controle_pilha_q <= 1'b0;
            load_temp1_q     <= 1'b0;
            load_temp2_q     <= 1'b0;
            temp_en_q        <= 1'b0;
            opcode_q         <= '0;
            din_uc_q         <= '0;
            busy_q           <= 1'b0;
            halted_q         <= 1'b0;
`ifdef STACK_GUARD_EN
            depth_q          <= '0;
`endif
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            instr_q          <= instr_d;
            error_q          <= error_d;
            instr_req_q      <= instr_req_d;
            pilha_en_q       <= pilha_en_d;
            wren_q           <= wren_d;
            controle_pilha_q <= controle_pilha_d;
            load_temp1_q     <= load_temp1_d;
            load_temp2_q     <= load_temp2_d;
            temp_en_q        <= temp_en_d;
            opcode_q         <= opcode_d;
            din_uc_q         <= din_uc_d;
            busy_q           <= busy_d;
            halted_q         <= halted_d;
`ifdef STACK_GUARD_EN
            depth_q          <= depth_d;
`endif
        end
    end

    assign instr_req      = instr_req_q;
    assign pc             = pc_q;
    assign pilha_en       = pilha_en_q;
    assign wren           = wren_q;
    assign controle_pilha = controle_pilha_q;
    assign load_temp1     = load_temp1_q;
    assign load_temp2     = load_temp2_q;
    assign temp_en        = temp_en_q;
    assign opcode         = opcode_q;
    assign din_UC         = din_uc_q;
    assign busy           = busy_q;
    assign halted         = halted_q;
    assign error          = error_q;

endmodule
`default_nettype wire

// File: doc/stack_control_unit.md
STACK_CONTROL_UNIT -- requirements
Module: stack_control_unit

Interface
REQ-001 Parameter: PC_W, 8, instruction address width.
REQ-002 Parameter: DEPTH, 16, stack entries tracked by the depth counter.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; forces reset state immediately.
REQ-005 start  in  1  one-cycle pulse; leaves IDLE/HALT and begins fetching at pc=0.
REQ-006 instr_req  out  1  request for the instruction at pc.
REQ-007 pc  out  PC_W  current instruction address.
REQ-008 instr  in  16  instruction word: [15:11] opcode, [10:0] immediate.
REQ-009 instr_valid  in  1  instr valid; sampled only while instr_req=1.
REQ-010 pilha_en  out  1  one-cycle stack operation strobe.
REQ-011 wren  out  1  stack direction qualifier: 1 = push, 0 = pop; meaningful only with pilha_en.
REQ-012 controle_pilha  out  1  push-data select: 0 = din_UC, 1 = ALU result.
REQ-013 load_temp1 / load_temp2  out  1 each  select which temp captures tos.
REQ-014 temp_en  out  1  temp capture strobe.
REQ-015 opcode  out  5  ALU opcode presented to the datapath.
REQ-016 din_UC  out  16  immediate data to the stack.
REQ-017 busy / halted / error  out  1 each  status flags.

Function
REQ-018 States: IDLE, FETCH, DECODE, PUSH, POP, POP_A, POP_B, EXEC, HALT.
REQ-019 IDLE: all strobes 0; start -> FETCH, pc=0, error=0.
REQ-020 FETCH: instr_req=1; on instr_valid=1 latch instr, pc<=pc+1 (wraps at 2^PC_W-1 -> 0), -> DECODE; otherwise hold indefinitely.
REQ-021 DECODE (1 cycle) on latched opcode: 00000 NOP -> FETCH; 00001 PUSH -> PUSH; 00010 POP -> POP; 00100-01111 binary ALU -> POP_A; 11111 HALT -> HALT; any other -> error=1 (sticky), treated as NOP.
REQ-022 PUSH (1 cycle): pilha_en=1, wren=1, controle_pilha=0, din_UC = sign-extended imm[10:0]; -> FETCH.
REQ-023 POP (1 cycle): pilha_en=1, wren=0; -> FETCH.
REQ-024 POP_A (1 cycle): pilha_en=1, wren=0, temp_en=1, load_temp1=1; -> POP_B.
REQ-025 POP_B (1 cycle): pilha_en=1, wren=0, temp_en=1, load_temp2=1; -> EXEC.
REQ-026 EXEC (1 cycle): pilha_en=1, wren=1, controle_pilha=1; -> FETCH.
REQ-027 opcode output holds the latched opcode from DECODE through EXEC; 00000 otherwise.
REQ-028 Minimum latency, instr_valid accepted to next instr_req: NOP 2 cycles, PUSH/POP 3, ALU 5.
REQ-029 HALT: halted=1, strobes 0; start -> FETCH with pc=0; start ignored in all other non-IDLE states.
REQ-030 busy=1 in every state except IDLE and HALT.
REQ-031 All outputs registered; at most one of load_temp1/load_temp2 high per cycle.

Reset
REQ-032 reset asserted in any state, including mid-instruction: state=IDLE, pc=0, all strobes/selects 0, opcode=0, din_UC=0, busy=0, halted=0, error=0, depth=0.

Configuration
REQ-033 Macro STACK_GUARD_EN: when defined, a depth counter (0..DEPTH) tracks pushes/pops; PUSH at depth=DEPTH, POP at depth=0, or ALU at depth<2 sets error=1, suppresses every strobe of that instruction, and proceeds to FETCH; EXEC nets depth -1.
REQ-034 Without STACK_GUARD_EN: no depth counter and no checks; error is set only by illegal opcodes.

Verification
REQ-035 reset, start, instr=0x0805 (PUSH 5) valid -> DECODE then one cycle pilha_en=1, wren=1, controle_pilha=0, din_UC=0x0005; pc=1.
REQ-036 PUSH imm 0x7FF -> din_UC=0xFFFF; followed by 0x2000 (ADD) -> POP_A, POP_B, EXEC strobes on consecutive cycles, opcode=00100 throughout, 5 cycles.
REQ-037 instr_valid held low 4 cycles in FETCH -> instr_req stays 1, pc unchanged, no strobes.
REQ-038 opcode 10101 -> error=1, no strobes, next fetch at pc+1; 0xF800 -> halted=1, busy=0.
REQ-039 STACK_GUARD_EN: POP at depth 0 -> error=1, pilha_en stays 0; 17 pushes with DEPTH=16 -> 17th suppressed, error=1.
REQ-040 reset asserted during POP_B -> all outputs 0 asynchronously, state IDLE; start restarts at pc=0.
